// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one conditional add per clock,
// fixed B_WIDTH-cycle latency, start/busy/done handshake.
module shift_add_multiplier #(
    parameter int  A_WIDTH = 6,
    parameter int  B_WIDTH = 5,
    localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] a_in,
    input  logic [B_WIDTH-1:0] b_in,
    output logic               busy,
    output logic               done,
    output logic [P_WIDTH-1:0] product
);

    localparam int CNT_W = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(B_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] acc_q, acc_d;
    logic [P_WIDTH-1:0] mcand_q, mcand_d;
    logic [B_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [P_WIDTH-1:0] product_q, product_d;
    logic [P_WIDTH-1:0] acc_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        // The sum cannot overflow: the full product always fits in P_WIDTH bits.
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d   = P_WIDTH'(a_in);
                    mplier_d  = b_in;
                    acc_d     = '0;
                    count_d   = '0;
                    product_d = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                // No early exit on a zero multiplier; latency stays fixed.
                if (count_q == LAST) begin
                    product_d = acc_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: scenario tasks with a queue
// of expected products filled at start and drained on each done pulse.
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  a_in;
    logic [4:0]  b_in;
    logic        busy;
    logic        done;
    logic [10:0] product;

    int          checks;
    int          errors;
    logic [10:0] exp_q[$];

    shift_add_multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Drive a start request at the current negedge and queue its expected product.
    task automatic issue(input logic [5:0] a, input logic [4:0] b, input bit push);
        logic [10:0] p;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        p = {5'b0, a} * {6'b0, b};
        if (push) exp_q.push_back(p);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 6'd7;
        b_in  = 5'd3;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checks++;
        if (product !== 11'd0) begin errors++; $display("FAIL reset_product: got %0d want 0", product); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: busy=%b done=%b want 0/0", busy, done);
            end
        end
    endtask

    task automatic test_max();
        logic [10:0] e;
        issue(6'd63, 5'd31, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k <= 5) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL max_busy_c%0d: busy=%b done=%b want 1/0", k, busy, done);
                end
            end else if (k == 6) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL max_done: done=%b busy=%b want 1/0", done, busy);
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
                checks++;
                if (product !== e) begin errors++; $display("FAIL max_product: got %0d want %0d", product, e); end
                checks++;
                if (product !== 11'd1953) begin errors++; $display("FAIL max_const: got %0d want 1953", product); end
            end else begin
                checks++;
                if (done !== 1'b0 || product !== 11'd1953) begin
                    errors++;
                    $display("FAIL max_after: done=%b product=%0d want 0/1953", done, product);
                end
            end
        end
    endtask

    task automatic test_edges();
        logic [5:0]  av[4];
        logic [4:0]  bv[4];
        logic [10:0] e;
        int          ndone;
        av = '{6'd0, 6'd45, 6'd1, 6'd2};
        bv = '{5'd31, 5'd0, 5'd1, 5'd31};
        for (int i = 0; i < 4; i++) begin
            ndone = 0;
            issue(av[i], bv[i], 1'b1);
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (k == 1) start = 1'b0;
                if (done === 1'b1) begin
                    ndone++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
                    checks++;
                    if (product !== e) begin
                        errors++;
                        $display("FAIL edge_product_%0dx%0d: got %0d want %0d", av[i], bv[i], product, e);
                    end
                end
            end
            checks++;
            if (ndone != 1) begin errors++; $display("FAIL edge_done_count_%0d: got %0d want 1", i, ndone); end
        end
    endtask

    task automatic test_ignore_start();
        logic [10:0] e;
        int          ndone;
        ndone = 0;
        issue(6'd13, 5'd7, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
                checks++;
                if (product !== e) begin errors++; $display("FAIL ignore_product: got %0d want %0d", product, e); end
            end
            if (k == 1) begin
                a_in = 6'd5; b_in = 5'd3; start = 1'b1;
            end else if (k == 2) begin
                start = 1'b0;
            end else if (k == 6) begin
                checks++;
                if (done !== 1'b1) begin errors++; $display("FAIL ignore_done_time: got %b want 1", done); end
                a_in = 6'd2; b_in = 5'd2; start = 1'b1;
            end else if (k == 7) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy=%b want 0", busy); end
            end
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        ndone = 0;
        issue(6'd2, 5'd2, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
                checks++;
                if (product !== e) begin errors++; $display("FAIL idle_start_product: got %0d want %0d", product, e); end
            end
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL idle_start_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_reset_midcalc();
        logic [10:0] e;
        int          ndone;
        ndone = 0;
        issue(6'd50, 5'd20, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || product !== 11'd0) begin
                    errors++;
                    $display("FAIL midreset: busy=%b done=%b product=%0d want 0/0/0", busy, done, product);
                end
            end
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", ndone); end
        ndone = 0;
        issue(6'd50, 5'd20, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
                checks++;
                if (product !== e || product !== 11'd1000) begin
                    errors++;
                    $display("FAIL after_reset_product: got %0d want %0d", product, e);
                end
            end
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL after_reset_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        logic [10:0] last;
        logic [5:0]  a;
        logic [4:0]  b;
        last = product;
        for (int i = 0; i < 200; i++) begin
            checks++;
            if (done !== 1'b0 || product !== last) begin
                errors++;
                $display("FAIL b2b_hold_%0d: done=%b product=%0d want 0/%0d", i, done, product, last);
            end
            a = 6'($urandom_range(0, 63));
            b = 5'($urandom_range(0, 31));
            issue(a, b, 1'b1);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    start = 1'b0;
                    a_in  = 6'($urandom);
                    b_in  = 5'($urandom);
                end
                if (k == 6) begin
                    checks++;
                    if (done !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_done_%0d: got %b want 1", i, done);
                    end
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
                    checks++;
                    if (product !== e) begin
                        errors++;
                        $display("FAIL b2b_product_%0d (%0dx%0d): got %0d want %0d", i, a, b, product, e);
                    end
                    last = product;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        @(negedge clk);
        test_reset();
        test_max();
        test_edges();
        test_ignore_start();
        test_reset_midcalc();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
